// File: rtl/ifu_fetch_pkg.sv
// Shared encodings for the instruction fetch unit: controller NPCSel values and fetch FSM states.
package ifu_fetch_pkg;

  typedef enum logic [1:0] {
    NPC_SEL_PC_ADD_4 = 2'b00,
    NPC_SEL_BEQ_JMP  = 2'b01,
    NPC_SEL_J_JMP    = 2'b10,
    NPC_SEL_REG_JMP  = 2'b11
  } npc_sel_e;

  typedef enum logic {
    IFU_ST_REQ  = 1'b0,
    IFU_ST_HOLD = 1'b1
  } ifu_state_e;

endpackage

// File: rtl/ifu_npc.sv
// Combinational next-PC selection from the controller's NPCSel and the latched instruction.
module ifu_npc
  import ifu_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] reg_target,
  output logic [31:0] npc
);

  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  logic [5:0]  unused_opcode;

  assign pc_plus4      = pc + 32'd4;
  assign br_off        = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign unused_opcode = instr[31:26];

  always_comb begin
    npc = pc_plus4;
    case (npc_sel_e'(npc_sel))
      NPC_SEL_PC_ADD_4: npc = pc_plus4;
      NPC_SEL_BEQ_JMP:  npc = pc_plus4 + br_off;
      NPC_SEL_J_JMP:    npc = {pc_plus4[31:28], instr[25:0], 2'b00};
      NPC_SEL_REG_JMP:  npc = reg_target;
      default:          npc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, fetches one word per instruction over req/ack, holds it until commit.
// Optional IFU_ALIGN_CHECK_EN redirects misaligned next-PCs to EXC_VEC and pulses addr_err.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
`ifdef IFU_ALIGN_CHECK_EN
  , parameter logic [31:0] EXC_VEC = 32'h0000_4180
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        commit,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] reg_target
`ifdef IFU_ALIGN_CHECK_EN
  , output logic      addr_err
`endif
);

  ifu_state_e  state_q, state_n;
  logic [31:0] pc_q, pc_n;
  logic [31:0] instr_q, instr_n;
  logic        valid_q, valid_n;
  logic        req_q, req_n;
  logic [31:0] npc;
  logic [31:0] npc_fix;

  ifu_npc u_npc (
    .pc         (pc_q),
    .instr      (instr_q),
    .npc_sel    (npc_sel),
    .reg_target (reg_target),
    .npc        (npc)
  );

`ifdef IFU_ALIGN_CHECK_EN
  logic aerr_q, aerr_n;
  logic misaligned;

  assign misaligned = |npc[1:0];
  assign npc_fix    = misaligned ? EXC_VEC : npc;
  assign addr_err   = aerr_q;
`else
  logic [1:0] unused_npc_lsbs;

  assign unused_npc_lsbs = npc[1:0];
  assign npc_fix         = {npc[31:2], 2'b00};
`endif

  // An ack only counts while the registered request is up, so the idle cycle
  // right after reset release cannot latch a stray response.
  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    instr_n = instr_q;
    valid_n = valid_q;
    req_n   = req_q;
`ifdef IFU_ALIGN_CHECK_EN
    aerr_n  = 1'b0;
`endif
    case (state_q)
      IFU_ST_REQ: begin
        if (req_q && imem_ack) begin
          instr_n = imem_rdata;
          valid_n = 1'b1;
          req_n   = 1'b0;
          state_n = IFU_ST_HOLD;
        end else begin
          req_n = 1'b1;
        end
      end
      IFU_ST_HOLD: begin
        if (commit) begin
          pc_n    = npc_fix;
          valid_n = 1'b0;
          req_n   = 1'b1;
          state_n = IFU_ST_REQ;
`ifdef IFU_ALIGN_CHECK_EN
          aerr_n  = misaligned;
`endif
        end
      end
      default: begin
        state_n = IFU_ST_REQ;
        req_n   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IFU_ST_REQ;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
      aerr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      instr_q <= instr_n;
      valid_q <= valid_n;
      req_q   <= req_n;
`ifdef IFU_ALIGN_CHECK_EN
      aerr_q  <= aerr_n;
`endif
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: a driver plays a directed fetch/commit table, a monitor checks each delivered instruction.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_ack = 1'b0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        commit = 1'b0;
  logic [1:0]  npc_sel = 2'b00;
  logic [31:0] reg_target = '0;
`ifdef IFU_ALIGN_CHECK_EN
  logic        addr_err;
`endif

  ifu_fetch #(.RESET_PC(32'h0000_3000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ack    (imem_ack),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .commit      (commit),
    .npc_sel     (npc_sel),
    .reg_target  (reg_target)
`ifdef IFU_ALIGN_CHECK_EN
    , .addr_err  (addr_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exp_pc;
    int          wait_n;
    logic [31:0] rdata;
    logic [1:0]  sel;
    logic [31:0] rt;
    logic        aerr;
  } step_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t  sb[$];
  step_t steps[14];
  int    n_pass = 0;
  int    n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every rising instr_valid must match the oldest outstanding fetch.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (instr_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon_pc", pc, e.pc);
        chk("mon_instr", instr, e.instr);
        chk("mon_pc_plus4", pc_plus4, e.pc + 32'd4);
      end
    end
    prev_valid <= instr_valid;
  end

  task automatic do_fetch(input step_t s);
    int n;
    n = 0;
    while (!imem_req && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_seen", {31'd0, imem_req}, 32'd1);
    chk("req_addr", imem_addr, s.exp_pc);
    for (int w = 0; w < s.wait_n; w++) begin
      commit = 1'b1;
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, s.exp_pc);
      chk("wait_valid", {31'd0, instr_valid}, 32'd0);
      @(posedge clk); #1;
    end
    commit = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = s.rdata;
    sb.push_back('{pc: s.exp_pc, instr: s.rdata});
    @(posedge clk); #1;
    chk("valid_after_ack", {31'd0, instr_valid}, 32'd1);
    chk("req_after_ack", {31'd0, imem_req}, 32'd0);
    imem_rdata = ~s.rdata;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    chk("hold_instr", instr, s.rdata);
    chk("hold_pc", pc, s.exp_pc);
    npc_sel = s.sel;
    reg_target = s.rt;
    commit = 1'b1;
    @(posedge clk); #1;
    commit = 1'b0;
    chk("valid_after_commit", {31'd0, instr_valid}, 32'd0);
    chk("req_after_commit", {31'd0, imem_req}, 32'd1);
`ifdef IFU_ALIGN_CHECK_EN
    chk("addr_err", {31'd0, addr_err}, {31'd0, s.aerr});
    if (s.aerr) begin
      @(posedge clk); #1;
      chk("addr_err_clear", {31'd0, addr_err}, 32'd0);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    steps[0]  = '{32'h0000_3000, 0, 32'h0800_0C10, 2'b00, 32'h0,         1'b0};
    steps[1]  = '{32'h0000_3004, 3, 32'h2400_0000, 2'b11, 32'h0000_3010, 1'b0};
    steps[2]  = '{32'h0000_3010, 0, 32'h1000_FFFE, 2'b01, 32'h0,         1'b0};
    steps[3]  = '{32'h0000_300C, 1, 32'h0000_0000, 2'b11, 32'h0000_3010, 1'b0};
    steps[4]  = '{32'h0000_3010, 0, 32'h1000_0004, 2'b01, 32'h0,         1'b0};
    steps[5]  = '{32'h0000_3024, 0, 32'h1000_FFFF, 2'b01, 32'h0,         1'b0};
    steps[6]  = '{32'h0000_3024, 2, 32'h03E0_0008, 2'b11, 32'h0000_3000, 1'b0};
    steps[7]  = '{32'h0000_3000, 0, 32'h0800_0C10, 2'b10, 32'h0,         1'b0};
    steps[8]  = '{32'h0000_3040, 0, 32'h03E0_0008, 2'b11, 32'h0000_3100, 1'b0};
`ifdef IFU_ALIGN_CHECK_EN
    steps[9]  = '{32'h0000_3100, 0, 32'h03E0_0008, 2'b11, 32'h0000_3102, 1'b1};
    steps[10] = '{32'h0000_4180, 0, 32'h03E0_0008, 2'b11, 32'hFFFF_FFFC, 1'b0};
`else
    steps[9]  = '{32'h0000_3100, 0, 32'h03E0_0008, 2'b11, 32'h0000_3102, 1'b0};
    steps[10] = '{32'h0000_3100, 0, 32'h03E0_0008, 2'b11, 32'hFFFF_FFFC, 1'b0};
`endif
    steps[11] = '{32'hFFFF_FFFC, 1, 32'h0000_0000, 2'b00, 32'h0,         1'b0};
    steps[12] = '{32'h0000_0000, 2, 32'h0000_0000, 2'b00, 32'h0,         1'b0};
    steps[13] = '{32'h0000_3000, 0, 32'h1234_5678, 2'b00, 32'h0,         1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc_plus4", pc_plus4, 32'h0000_3004);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) do_fetch(steps[i]);

    // Now requesting at pc=4; reset arrives while an ack is being presented.
    chk("pre_abort_addr", imem_addr, 32'h0000_0004);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_req", {31'd0, imem_req}, 32'd0);
    chk("abort_pc", pc, 32'h0000_3000);
    chk("abort_valid", {31'd0, instr_valid}, 32'd0);
    @(posedge clk); #1;
    imem_ack = 1'b0;
    chk("abort_instr", instr, 32'h0);
    chk("abort_valid_late", {31'd0, instr_valid}, 32'd0);
    rst_n = 1'b1;

    do_fetch(steps[13]);
    chk("final_addr", imem_addr, 32'h0000_3004);
    repeat (2) @(posedge clk);
    chk("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit upstream of the decode controller. It owns the PC and computes the next PC from the controller's NPCSel.
- Fetches one word per instruction from instruction memory over a req/ack handshake.
- Holds the fetched instruction stable, so opcode/funct feed the controller, until the datapath signals commit.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_VEC, 32'h0000_4180, redirect target for a misaligned next PC (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equals pc.
- imem_rdata  in  32  instruction word; valid when imem_ack=1.
- imem_ack  in  1  memory response strobe.
- instr  out  32  latched instruction to decode (opcode=instr[31:26], funct=instr[5:0]).
- instr_valid  out  1  instr is valid and stable.
- pc  out  32  address of the current instruction.
- pc_plus4  out  32  pc+4, used as the jal return value.
- commit  in  1  current instruction retires this cycle; PC advances.
- npc_sel  in  2  controller NPCSel.
- reg_target  in  32  rs value for jr.
- addr_err  out  1  misaligned-target pulse (present only with IFU_ALIGN_CHECK_EN).

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset values: pc=RESET_PC, state=REQ, instr=0, instr_valid=0, addr_err=0.
- imem_req is registered and reads 0 while rst_n=0. It goes to 1 on the first clock edge after release.
- Shared encoding in macro.v: NPC_SEL_PC_ADD_4=2'b00, NPC_SEL_BEQ_JMP=2'b01, NPC_SEL_J_JMP=2'b10, NPC_SEL_REG_JMP=2'b11.
- FSM, two states: REQ and HOLD.
- REQ:
  - imem_req=1 and imem_addr=pc, both held stable until imem_ack.
  - On an edge with imem_ack=1: instr<=imem_rdata, instr_valid<=1, imem_req<=0, next state HOLD.
  - Any number of wait cycles is legal.
- HOLD:
  - instr, pc and instr_valid stay stable.
  - On an edge with commit=1: pc<=npc, instr_valid<=0, imem_req<=1, next state REQ.
- Next-PC computation (32-bit modulo arithmetic; imm16 and index come from the latched instr):
  - PC_ADD_4: pc+4.
  - BEQ_JMP: pc+4 + {{14{instr[15]}}, instr[15:0], 2'b00}.
  - J_JMP: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - REG_JMP: reg_target.
- Latency: commit edge -> imem_req high; ack edge -> instr_valid high. With a zero-wait memory (ack in the first req cycle), instr_valid returns 2 edges after commit.
- Boundary conditions:
  - commit in REQ is ignored.
  - imem_ack in HOLD is ignored.
  - pc=32'hFFFF_FFFC with PC_ADD_4 wraps to 0.
  - A backward branch with imm16=16'hFFFF gives npc=pc.
  - Reset mid-request abandons the request immediately; no late instr latch.
- pc_plus4 is combinational, pc+4.

Optional Feature:
- Macro: IFU_ALIGN_CHECK_EN.
- Defined:
  - If the computed npc[1:0]!=0 at commit, pc<=EXC_VEC instead.
  - addr_err is high for exactly one cycle, the cycle after that commit edge.
- Undefined:
  - The addr_err port is absent.
  - npc[1:0] is forced to 2'b00.

Decomposition:
- macro.v gains the NPC_SEL_* encodings and the IFU_ST_REQ/IFU_ST_HOLD state constants.
- One natural combinational sub-module, ifu_npc: inputs pc, instr, npc_sel, reg_target; output npc.
- The FSM and PC register remain in ifu_fetch.

Test Plan:
1. Reset, then release with zero-wait memory.
   -> imem_addr=0x3000 on the first req cycle.
   -> instr_valid=1 after the ack edge.
   -> commit with PC_ADD_4 gives a next fetch at 0x3004.
2. 3 wait cycles before ack.
   -> imem_req/imem_addr stable at 0x3004 for all 4 cycles.
   -> instr_valid stays 0 until the ack edge.
3. pc=0x3010, instr imm16=0xFFFE, BEQ_JMP commit.
   -> next pc=0x300C.
   -> repeat with imm16=0x0004 -> 0x3024.
4. pc=0x3000, instr[25:0]=0x0000C10, J_JMP commit -> 0x3040.
5. REG_JMP with reg_target=0x0000_3100 -> 0x3100.
   - With IFU_ALIGN_CHECK_EN and reg_target=0x3102: pc=0x4180 and addr_err pulses one cycle.
   - Without IFU_ALIGN_CHECK_EN, the same stimulus gives 0x3100.
6. Boundary and reset cases:
   - pc=0xFFFF_FFFC with PC_ADD_4 -> 0x0.
   - rst_n low mid-REQ -> imem_req=0 immediately, pc=0x3000.
   - commit pulsed during REQ -> no effect.
